// File: rtl/tis_node_ctrl.sv
// Sequencing controller for one TIS-100 execution node: decodes instruction
// fields into data-path strobes and runs the blocking port read/write handshakes.
module tis_node_ctrl #(
  parameter int unsigned STALL_W = 8,
  parameter int unsigned NPORT   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic [4:0]         instrType,
  input  logic [2:0]         sType,
  input  logic [1:0]         dType,
  input  logic [1:0]         dPort,
  input  logic [7:0]         ACCond,
  input  logic [NPORT-1:0]   rd_ack,
  input  logic [NPORT-1:0]   wr_ack,
  output logic [NPORT-1:0]   rd_req,
  output logic [NPORT-1:0]   wr_req,
  output logic               acc_we,
  output logic               enBak,
  output logic               SwpActiveReg,
  output logic [1:0]         ALUdesk,
  output logic               jmpInstr,
  output logic               hold_en,
  output logic               hlt,
  output logic [STALL_W-1:0] stall_cnt
);

  localparam logic [4:0] OP_MOV = 5'd1;
  localparam logic [4:0] OP_SWP = 5'd2;
  localparam logic [4:0] OP_SAV = 5'd3;
  localparam logic [4:0] OP_ADD = 5'd4;
  localparam logic [4:0] OP_SUB = 5'd5;
  localparam logic [4:0] OP_NEG = 5'd6;
  localparam logic [4:0] OP_JMP = 5'd7;
  localparam logic [4:0] OP_JEZ = 5'd8;
  localparam logic [4:0] OP_JNZ = 5'd9;
  localparam logic [4:0] OP_JGZ = 5'd10;
  localparam logic [4:0] OP_JLZ = 5'd11;

  localparam logic [1:0] D_ACC  = 2'd0;
  localparam logic [1:0] D_PORT = 2'd2;
  localparam logic [STALL_W-1:0] STALL_MAX = '1;

  typedef enum logic [1:0] {EXEC, WAIT_RD, WAIT_WR} state_t;

  state_t               state_q, state_d;
  logic [STALL_W-1:0]   stall_q, stall_d;

  logic       is_port_src, uses_src, mov_to_port, acc_zero;
  logic [1:0] src_port;
  logic       ex_acc_we, ex_bak, ex_swp, ex_jmp;
  logic [1:0] ex_alu;

  assign is_port_src = (sType >= 3'd3) && (sType <= 3'd6);
  assign src_port    = 2'(sType - 3'd3);
  assign uses_src    = (instrType == OP_MOV) || (instrType == OP_ADD) || (instrType == OP_SUB);
  assign mov_to_port = (instrType == OP_MOV) && (dType == D_PORT);
  assign acc_zero    = (ACCond == 8'd0);

  // Single-cycle strobe decode, shared by EXEC and read-completion
  always_comb begin
    ex_acc_we = 1'b0;
    ex_bak    = 1'b0;
    ex_swp    = 1'b0;
    ex_jmp    = 1'b0;
    ex_alu    = 2'b00;
    case (instrType)
      OP_MOV: ex_acc_we = (dType == D_ACC);
      OP_SWP: ex_swp    = 1'b1;
      OP_SAV: ex_bak    = 1'b1;
      OP_ADD: begin ex_acc_we = 1'b1; ex_alu = 2'b01; end
      OP_SUB: begin ex_acc_we = 1'b1; ex_alu = 2'b10; end
      OP_NEG: begin ex_acc_we = 1'b1; ex_alu = 2'b11; end
      OP_JMP: ex_jmp = 1'b1;
      OP_JEZ: ex_jmp = acc_zero;
      OP_JNZ: ex_jmp = !acc_zero;
      OP_JGZ: ex_jmp = !ACCond[7] && !acc_zero;
      OP_JLZ: ex_jmp = ACCond[7];
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    rd_req       = '0;
    wr_req       = '0;
    acc_we       = 1'b0;
    enBak        = 1'b0;
    SwpActiveReg = 1'b0;
    ALUdesk      = 2'b00;
    jmpInstr     = 1'b0;
    hold_en      = 1'b0;
    hlt          = 1'b0;
    case (state_q)
      EXEC: begin
        if (uses_src && is_port_src) begin
          hlt     = 1'b1;
          state_d = WAIT_RD;
        end else if (mov_to_port) begin
          hlt     = 1'b1;
          state_d = WAIT_WR;
        end else begin
          acc_we       = ex_acc_we;
          enBak        = ex_bak;
          SwpActiveReg = ex_swp;
          ALUdesk      = ex_alu;
          jmpInstr     = ex_jmp;
        end
      end
      WAIT_RD: begin
        rd_req[src_port] = 1'b1;
        hlt              = 1'b1;
        if (rd_ack[src_port]) begin
          if (mov_to_port) begin
            hold_en = 1'b1;
            state_d = WAIT_WR;
          end else begin
            acc_we   = ex_acc_we;
            ALUdesk  = ex_alu;
            hlt      = 1'b0;
            state_d  = EXEC;
          end
        end
      end
      WAIT_WR: begin
        wr_req[dPort] = 1'b1;
        hlt           = 1'b1;
        if (wr_ack[dPort]) begin
          hlt     = 1'b0;
          state_d = EXEC;
        end
      end
      default: state_d = EXEC;
    endcase
    // Reset or run=0 forces an idle, halted node and abandons any handshake
    if (reset || !run) begin
      state_d      = EXEC;
      rd_req       = '0;
      wr_req       = '0;
      acc_we       = 1'b0;
      enBak        = 1'b0;
      SwpActiveReg = 1'b0;
      ALUdesk      = 2'b00;
      jmpInstr     = 1'b0;
      hold_en      = 1'b0;
      hlt          = 1'b1;
    end
  end

  // Counts cycles spent waiting, including the current one
  always_comb begin
    stall_d = '0;
    if (state_d != EXEC) begin
      stall_d = (stall_q == STALL_MAX) ? stall_q : stall_q + STALL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EXEC;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_tis_node_ctrl.sv
// Directed-vector bench for tis_node_ctrl with hand-computed expectations.
module tb_tis_node_ctrl;

  logic       clk = 1'b0;
  logic       reset, run;
  logic [4:0] instrType;
  logic [2:0] sType;
  logic [1:0] dType, dPort;
  logic [7:0] ACCond;
  logic [3:0] rd_ack, wr_ack, rd_req, wr_req;
  logic       acc_we, enBak, SwpActiveReg, jmpInstr, hold_en, hlt;
  logic [1:0] ALUdesk;
  logic [7:0] stall_cnt;

  int n_vec = 0;
  int n_err = 0;

  tis_node_ctrl #(.STALL_W(8), .NPORT(4)) dut (
    .clk(clk), .reset(reset), .run(run), .instrType(instrType), .sType(sType),
    .dType(dType), .dPort(dPort), .ACCond(ACCond), .rd_ack(rd_ack), .wr_ack(wr_ack),
    .rd_req(rd_req), .wr_req(wr_req), .acc_we(acc_we), .enBak(enBak),
    .SwpActiveReg(SwpActiveReg), .ALUdesk(ALUdesk), .jmpInstr(jmpInstr),
    .hold_en(hold_en), .hlt(hlt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic instr(input logic [4:0] op, input logic [2:0] s, input logic [1:0] d,
                       input logic [1:0] dp, input logic [7:0] acc);
    instrType = op; sType = s; dType = d; dPort = dp; ACCond = acc;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {acc_we, enBak, SwpActiveReg, ALUdesk, jmpInstr, hold_en}
  function automatic logic [6:0] strobes();
    return {acc_we, enBak, SwpActiveReg, ALUdesk, jmpInstr, hold_en};
  endfunction

  initial begin
    reset = 1'b1; run = 1'b0; rd_ack = '0; wr_ack = '0;
    instr(5'd0, 3'd1, 2'd1, 2'd0, 8'd0);
    step(); step();
    chk("rst_hlt", 32'(hlt), 32'd1);
    chk("rst_req", 32'({rd_req, wr_req}), 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    reset = 1'b0; run = 1'b1;
    step();

    // Single-cycle opcodes
    instr(5'd4, 3'd2, 2'd0, 2'd0, 8'h00);
    chk("add_strb", 32'(strobes()), 32'b1_0_0_01_0_0);
    chk("add_hlt", 32'(hlt), 32'd0);
    step();
    instr(5'd10, 3'd1, 2'd1, 2'd0, 8'h05);
    chk("jgz_pos", 32'(jmpInstr), 32'd1);
    step();
    instr(5'd10, 3'd1, 2'd1, 2'd0, 8'h80);
    chk("jgz_neg", 32'(jmpInstr), 32'd0);
    instr(5'd10, 3'd1, 2'd1, 2'd0, 8'h00);
    chk("jgz_zero", 32'(jmpInstr), 32'd0);
    instr(5'd11, 3'd1, 2'd1, 2'd0, 8'h80);
    chk("jlz_neg", 32'(jmpInstr), 32'd1);
    instr(5'd11, 3'd1, 2'd1, 2'd0, 8'h7F);
    chk("jlz_pos", 32'(jmpInstr), 32'd0);
    instr(5'd8, 3'd1, 2'd1, 2'd0, 8'h00);
    chk("jez_zero", 32'(jmpInstr), 32'd1);
    instr(5'd9, 3'd1, 2'd1, 2'd0, 8'h00);
    chk("jnz_zero", 32'(jmpInstr), 32'd0);
    instr(5'd9, 3'd1, 2'd1, 2'd0, 8'hFF);
    chk("jnz_nz", 32'(jmpInstr), 32'd1);
    instr(5'd7, 3'd1, 2'd1, 2'd0, 8'h00);
    chk("jmp", 32'(jmpInstr), 32'd1);
    instr(5'd5, 3'd0, 2'd0, 2'd0, 8'h00);
    chk("sub_strb", 32'(strobes()), 32'b1_0_0_10_0_0);
    instr(5'd6, 3'd1, 2'd0, 2'd0, 8'h00);
    chk("neg_strb", 32'(strobes()), 32'b1_0_0_11_0_0);
    instr(5'd1, 3'd2, 2'd0, 2'd0, 8'h00);
    chk("mov_acc", 32'(strobes()), 32'b1_0_0_00_0_0);
    instr(5'd1, 3'd2, 2'd1, 2'd0, 8'h00);
    chk("mov_nil", 32'(strobes()), 32'd0);
    step();
    instr(5'd2, 3'd1, 2'd1, 2'd0, 8'h00);
    chk("swp_strb", 32'(strobes()), 32'b0_0_1_00_0_0);
    step();
    instr(5'd3, 3'd1, 2'd1, 2'd0, 8'h00);
    chk("sav_strb", 32'(strobes()), 32'b0_1_0_00_0_0);
    step();
    instr(5'd20, 3'd5, 2'd2, 2'd1, 8'h00);
    chk("op20_strb", 32'(strobes()), 32'd0);
    chk("op20_hlt", 32'(hlt), 32'd0);
    chk("op20_req", 32'({rd_req, wr_req}), 32'd0);
    step();

    // MOV UP -> ACC with three wait cycles
    instr(5'd1, 3'd5, 2'd0, 2'd0, 8'h00);
    chk("up_ex_hlt", 32'(hlt), 32'd1);
    chk("up_ex_req", 32'(rd_req), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("up_wait_req", 32'(rd_req), 32'b0100);
      chk("up_wait_hlt", 32'(hlt), 32'd1);
      chk("up_wait_cnt", 32'(stall_cnt), 32'(i));
    end
    rd_ack = 4'b0100; #1;
    chk("up_ack_we", 32'(acc_we), 32'd1);
    chk("up_ack_hlt", 32'(hlt), 32'd0);
    chk("up_ack_req", 32'(rd_req), 32'b0100);
    step();
    rd_ack = '0;
    instr(5'd0, 3'd1, 2'd1, 2'd0, 8'h00);
    chk("up_done_req", 32'(rd_req), 32'd0);
    chk("up_done_cnt", 32'(stall_cnt), 32'd0);
    step();

    // MOV LEFT -> DOWN through the holding register
    instr(5'd1, 3'd3, 2'd2, 2'd3, 8'h00);
    chk("ld_ex_hlt", 32'(hlt), 32'd1);
    step();
    chk("ld_rd_req", 32'(rd_req), 32'b0001);
    chk("ld_rd_hold", 32'(hold_en), 32'd0);
    step();
    rd_ack = 4'b0001; #1;
    chk("ld_hold", 32'(hold_en), 32'd1);
    chk("ld_hold_hlt", 32'(hlt), 32'd1);
    step();
    rd_ack = '0; wr_ack = 4'b0001; #1;
    chk("ld_wr_req", 32'({rd_req, wr_req}), 32'b0000_1000);
    chk("ld_wr_wrong", 32'(hlt), 32'd1);
    step();
    wr_ack = 4'b1000; #1;
    chk("ld_wr_hlt", 32'(hlt), 32'd0);
    chk("ld_wr_cnt", 32'(stall_cnt), 32'd4);
    step();
    wr_ack = '0;
    instr(5'd0, 3'd1, 2'd1, 2'd0, 8'h00);
    chk("ld_done", 32'({rd_req, wr_req, hlt}), 32'd0);
    step();

    // Zero-wait write: ack already present when the request rises
    wr_ack = 4'b0010;
    instr(5'd1, 3'd0, 2'd2, 2'd1, 8'h00);
    chk("zw_ex_hlt", 32'(hlt), 32'd1);
    step();
    chk("zw_req", 32'(wr_req), 32'b0010);
    chk("zw_hlt", 32'(hlt), 32'd0);
    step();
    wr_ack = '0;
    instr(5'd0, 3'd1, 2'd1, 2'd0, 8'h00);
    chk("zw_done", 32'({wr_req, hlt}), 32'd0);
    step();

    // Long read wait on LEFT with a spurious ack on RIGHT
    instr(5'd1, 3'd3, 2'd0, 2'd0, 8'h00);
    step();
    rd_ack = 4'b0010;
    for (int i = 0; i < 300; i++) step();
    chk("sat_cnt", 32'(stall_cnt), 32'd255);
    chk("sat_req", 32'(rd_req), 32'b0001);
    chk("sat_spur", 32'({hlt, acc_we}), 32'b10);
    rd_ack = 4'b0001; #1;
    chk("sat_ack", 32'({hlt, acc_we}), 32'b01);
    step();
    rd_ack = '0;

    // run=0 during a read wait aborts it
    instr(5'd4, 3'd4, 2'd0, 2'd0, 8'h00);
    step();
    chk("run_wait_req", 32'(rd_req), 32'b0010);
    run = 1'b0; #1;
    chk("run0_out", 32'({rd_req, wr_req, strobes(), hlt}), 32'd1);
    step();
    chk("run0_cnt", 32'(stall_cnt), 32'd0);
    run = 1'b1;
    instr(5'd0, 3'd1, 2'd1, 2'd0, 8'h00);
    chk("run1_exec", 32'({rd_req, hlt}), 32'd0);
    step();

    // Asynchronous reset during a write wait
    instr(5'd1, 3'd0, 2'd2, 2'd2, 8'h00);
    step();
    chk("rw_req", 32'(wr_req), 32'b0100);
    chk("rw_cnt", 32'(stall_cnt), 32'd1);
    #2 reset = 1'b1; #1;
    chk("rw_rst_req", 32'(wr_req), 32'd0);
    chk("rw_rst_hlt", 32'(hlt), 32'd1);
    chk("rw_rst_cnt", 32'(stall_cnt), 32'd0);
    step();
    reset = 1'b0;
    instr(5'd0, 3'd1, 2'd1, 2'd0, 8'h00);
    step();
    chk("rw_exec", 32'({wr_req, hlt}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
